// File: rtl/mem_req_ctrl.sv
// ----------------------------------------------------------------------------
// mem_req_ctrl
//
// Initiator side of the processor / data-memory request interface. Accepts
// one load or store at a time from the pipeline, decodes the RISC-V funct3
// into a size/sign mask, checks alignment, issues a one-cycle strobe to the
// data memory, follows the memory's clk_stall handshake and returns a
// one-cycle response carrying load data or an error code. A wait that never
// sees its exit condition is aborted after TIMEOUT cycles.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   req_valid/ready   pipeline request handshake (accept on valid && ready)
//   req_we            1 = store, 0 = load
//   req_funct3        RISC-V load/store funct3
//   req_addr          byte address
//   req_wdata         store data, unshifted
//   resp_valid        one-cycle response pulse
//   resp_err          00 ok, 01 misaligned, 10 illegal funct3, 11 timeout
//   resp_rdata        load result (0 for stores and errors)
//   memread/memwrite  memory strobes, high for one cycle per access
//   addr/write_data   memory address / store data, held between accepts
//   sign_mask         [3] sign-extend, [2:0] size (001/011/111)
//   clk_stall         memory busy
//   read_data         memory load data, already extended by the memory
// ----------------------------------------------------------------------------
module mem_req_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [1:0]  resp_err,
    output logic [31:0] resp_rdata,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] addr,
    output logic [31:0] write_data,
    output logic [3:0]  sign_mask,
    input  logic        clk_stall,
    input  logic [31:0] read_data
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             isStore_q, isStore_d;
    logic             memread_q, memread_d;
    logic             memwrite_q, memwrite_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       mask_q, mask_d;
    logic             respValid_q, respValid_d;
    logic [1:0]       respErr_q, respErr_d;
    logic [31:0]      respRdata_q, respRdata_d;

    logic             decLegal;
    logic             decMisaligned;
    logic [3:0]       decMask;
    logic [1:0]       decErr;
    logic             accept;

    // Request decode: funct3 to size/sign mask, legality and alignment.
    // Unsigned loads (100/101) have no store counterpart, so they are illegal
    // with req_we set. Illegal wins over misaligned.
    always_comb begin
        decLegal = 1'b1;
        decMask  = 4'b0000;
        case (req_funct3)
            3'b000:  decMask = req_we ? 4'b0001 : 4'b1001;
            3'b001:  decMask = req_we ? 4'b0011 : 4'b1011;
            3'b010:  decMask = 4'b0111;
            3'b100: begin
                decMask  = 4'b0001;
                decLegal = !req_we;
            end
            3'b101: begin
                decMask  = 4'b0011;
                decLegal = !req_we;
            end
            default: decLegal = 1'b0;
        endcase

        decMisaligned = ((decMask[2:0] == 3'b011) && req_addr[0]) ||
                        ((decMask[2:0] == 3'b111) && (req_addr[1:0] != 2'b00));

        if (!decLegal) begin
            decErr = ERR_ILLEGAL;
        end else if (decMisaligned) begin
            decErr = ERR_MISALIGN;
        end else begin
            decErr = ERR_OK;
        end
    end

    // Ready is gated by clk_stall so that after a mid-access reset no new
    // issue starts until the memory's in-flight access has drained.
    assign req_ready = (state_q == IDLE) && !clk_stall;
    assign accept    = req_valid && req_ready;

    // Next-state and output logic. Strobes and resp_valid default low so each
    // is a single-cycle pulse; the address/data/mask registers hold until the
    // next accepted access.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        isStore_d   = isStore_q;
        memread_d   = 1'b0;
        memwrite_d  = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        respValid_d = 1'b0;
        respErr_d   = respErr_q;
        respRdata_d = respRdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (decErr != ERR_OK) begin
                        respValid_d = 1'b1;
                        respErr_d   = decErr;
                        respRdata_d = 32'h0;
                    end else begin
                        addr_d     = req_addr;
                        wdata_d    = req_wdata;
                        mask_d     = decMask;
                        isStore_d  = req_we;
                        memread_d  = !req_we;
                        memwrite_d = req_we;
                        state_d    = ISSUE;
                    end
                end
            end

            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_HI;
            end

            WAIT_HI: begin
                if (clk_stall) begin
                    cnt_d   = '0;
                    state_d = WAIT_LO;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    respValid_d = 1'b1;
                    respErr_d   = ERR_TIMEOUT;
                    respRdata_d = 32'h0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_LO: begin
                if (!clk_stall) begin
                    cnt_d       = '0;
                    respValid_d = 1'b1;
                    respErr_d   = ERR_OK;
                    respRdata_d = isStore_q ? 32'h0 : read_data;
                    state_d     = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    respValid_d = 1'b1;
                    respErr_d   = ERR_TIMEOUT;
                    respRdata_d = 32'h0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops the strobes immediately and
    // discards any outstanding response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            isStore_q   <= 1'b0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            mask_q      <= 4'h0;
            respValid_q <= 1'b0;
            respErr_q   <= 2'b00;
            respRdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            isStore_q   <= isStore_d;
            memread_q   <= memread_d;
            memwrite_q  <= memwrite_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            respValid_q <= respValid_d;
            respErr_q   <= respErr_d;
            respRdata_q <= respRdata_d;
        end
    end

    assign memread    = memread_q;
    assign memwrite   = memwrite_q;
    assign addr       = addr_q;
    assign write_data = wdata_q;
    assign sign_mask  = mask_q;
    assign resp_valid = respValid_q;
    assign resp_err   = respErr_q;
    assign resp_rdata = respRdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_req_ctrl
//
// Testbench for mem_req_ctrl. Contains a byte-addressed data memory that
// answers strobes with a two-cycle clk_stall, and a separate reference
// memory plus request model that predicts error codes, masks, latency and
// load data directly from the RISC-V load/store rules.
// ----------------------------------------------------------------------------
module tb_mem_req_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [1:0]  resp_err;
    logic [31:0] resp_rdata;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [3:0]  sign_mask;
    logic        clk_stall = 1'b0;
    logic [31:0] read_data = 32'h0;

    int checkCount = 0;
    int errorCount = 0;

    mem_req_ctrl #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .memread    (memread),
        .memwrite   (memwrite),
        .addr       (addr),
        .write_data (write_data),
        .sign_mask  (sign_mask),
        .clk_stall  (clk_stall),
        .read_data  (read_data)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: samples a strobe, stalls for two cycles, then performs
    // the access and presents read data as the stall falls. It is not reset
    // by rst_n, so an access in flight drains on its own.
    logic [7:0]  memBytes [0:255];
    bit          noStall = 1'b0;
    int          stallCnt = 0;
    logic        mWe;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    logic [3:0]  mMask;

    function automatic int maskSize(input logic [3:0] m);
        return (m[2:0] == 3'b001) ? 1 : (m[2:0] == 3'b011) ? 2 : 4;
    endfunction

    function automatic logic [31:0] memLoad(input logic [31:0] a, input logic [3:0] m);
        logic [31:0] v;
        logic [7:0]  idx;
        int          n;
        n = maskSize(m);
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            idx = a[7:0] + 8'(i);
            v[8*i +: 8] = memBytes[idx];
        end
        if (m[3] && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (m[3] && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    always @(posedge clk) begin
        logic [7:0] widx;
        if (stallCnt > 0) begin
            stallCnt <= stallCnt - 1;
            if (stallCnt == 1) begin
                clk_stall <= 1'b0;
                if (mWe) begin
                    for (int i = 0; i < maskSize(mMask); i++) begin
                        widx = mAddr[7:0] + 8'(i);
                        memBytes[widx] = mWdata[8*i +: 8];
                    end
                end else begin
                    read_data <= memLoad(mAddr, mMask);
                end
            end
        end else if ((memread || memwrite) && !noStall) begin
            clk_stall <= 1'b1;
            stallCnt  <= 2;
            mWe       <= memwrite;
            mAddr     <= addr;
            mWdata    <= write_data;
            mMask     <= sign_mask;
        end
    end

    // Reference memory, kept in step with memBytes only through the model.
    logic [7:0] refBytes [0:255];

    // Reference request model: derives the expected outcome of one request
    // from the load/store rules and applies completed stores to refBytes.
    task automatic refModel(input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [1:0] expErr, output logic [3:0] expMask,
                            output logic [31:0] expData, output int expLat,
                            output bit expStrobe);
        int          size;
        bit          isSigned;
        bit          legal;
        logic [7:0]  idx;
        legal    = 1'b1;
        size     = 4;
        isSigned = 1'b0;
        case (f3)
            3'd0: begin size = 1; isSigned = 1'b1; end
            3'd1: begin size = 2; isSigned = 1'b1; end
            3'd2: begin size = 4; isSigned = 1'b0; end
            3'd4: begin size = 1; isSigned = 1'b0; end
            3'd5: begin size = 2; isSigned = 1'b0; end
            default: legal = 1'b0;
        endcase
        if (we && f3 > 3'd3) legal = 1'b0;

        if (!legal)                 expErr = 2'b10;
        else if (a % size != 0)     expErr = 2'b01;
        else if (noStall)           expErr = 2'b11;
        else                        expErr = 2'b00;

        expMask      = 4'h0;
        expMask[3]   = isSigned && !we && size < 4;
        expMask[2:0] = (size == 1) ? 3'b001 : (size == 2) ? 3'b011 : 3'b111;

        expStrobe = (expErr == 2'b00) || (expErr == 2'b11);
        expLat    = (expErr == 2'b11) ? 18 : (expErr == 2'b00) ? 5 : 1;

        expData = 32'h0;
        if (expErr == 2'b00) begin
            if (we) begin
                for (int i = 0; i < size; i++) begin
                    idx = a[7:0] + 8'(i);
                    refBytes[idx] = wd[8*i +: 8];
                end
            end else begin
                for (int i = 0; i < size; i++) begin
                    idx = a[7:0] + 8'(i);
                    expData = expData | (32'(refBytes[idx]) << (8 * i));
                end
                if (isSigned && size == 1 && expData[7])  expData = expData | 32'hFFFF_FF00;
                if (isSigned && size == 2 && expData[15]) expData = expData | 32'hFFFF_0000;
            end
        end
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Runs one request end to end and compares everything observable.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
        logic [1:0]  expErr;
        logic [3:0]  expMask;
        logic [31:0] expData;
        int          expLat;
        bit          expStrobe;
        int          guard;
        int          cycles;
        bit          seen;
        int          rdCnt;
        int          wrCnt;
        logic [1:0]  errCap;
        logic [31:0] dataCap;
        logic [3:0]  maskCap;
        logic [31:0] addrCap;
        logic [31:0] wdCap;

        refModel(we, f3, a, wd, expErr, expMask, expData, expLat, expStrobe);

        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("readyWait", 32'(guard < 50), 32'd1);

        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        cycles = 0; seen = 1'b0; rdCnt = 0; wrCnt = 0;
        errCap = 2'b00; dataCap = 32'h0; maskCap = 4'h0; addrCap = 32'h0; wdCap = 32'h0;
        while (!seen && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (memread || memwrite) begin
                maskCap = sign_mask;
                addrCap = addr;
                wdCap   = write_data;
            end
            if (memread)  rdCnt++;
            if (memwrite) wrCnt++;
            if (resp_valid) begin
                seen    = 1'b1;
                errCap  = resp_err;
                dataCap = resp_rdata;
            end
        end

        checkOutput("respSeen", 32'(seen), 32'd1);
        checkOutput("latency", 32'(cycles), 32'(expLat));
        checkOutput("respErr", 32'(errCap), 32'(expErr));
        checkOutput("respData", dataCap, expData);
        checkOutput("readStrobe", 32'(rdCnt), 32'(expStrobe && !we));
        checkOutput("writeStrobe", 32'(wrCnt), 32'(expStrobe && we));
        if (expStrobe) begin
            checkOutput("signMask", 32'(maskCap), 32'(expMask));
            checkOutput("memAddr", addrCap, a);
            if (we) checkOutput("writeData", wdCap, wd);
        end

        @(negedge clk);
        checkOutput("respPulse", 32'(resp_valid), 32'd0);
    endtask

    // Directed test-plan items, a timeout, a mid-access reset, then random
    // traffic against the reference model.
    initial begin
        logic [7:0]  b;
        logic        rWe;
        logic [2:0]  rF3;
        logic [31:0] rA;

        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            memBytes[i] = b;
            refBytes[i] = b;
        end
        memBytes[8'h04] = 8'hEF; refBytes[8'h04] = 8'hEF;
        memBytes[8'h05] = 8'hBE; refBytes[8'h05] = 8'hBE;
        memBytes[8'h06] = 8'hAD; refBytes[8'h06] = 8'hAD;
        memBytes[8'h07] = 8'hDE; refBytes[8'h07] = 8'hDE;
        memBytes[8'h03] = 8'h80; refBytes[8'h03] = 8'h80;

        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstRespValid", 32'(resp_valid), 32'd0);
        checkOutput("rstRespErr", 32'(resp_err), 32'd0);
        checkOutput("rstRespData", resp_rdata, 32'h0);
        checkOutput("rstMemread", 32'(memread), 32'd0);
        checkOutput("rstMemwrite", 32'(memwrite), 32'd0);
        checkOutput("rstAddr", addr, 32'h0);
        checkOutput("rstWdata", write_data, 32'h0);
        checkOutput("rstMask", 32'(sign_mask), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b0, 3'd2, 32'h1004, 32'h0);
        applyStimulus(1'b0, 3'd0, 32'h1003, 32'h0);
        applyStimulus(1'b0, 3'd4, 32'h1003, 32'h0);
        applyStimulus(1'b1, 3'd1, 32'h1002, 32'h1234ABCD);
        applyStimulus(1'b0, 3'd5, 32'h1002, 32'h0);
        applyStimulus(1'b0, 3'd2, 32'h1001, 32'h0);
        applyStimulus(1'b1, 3'd4, 32'h1000, 32'h55AA55AA);
        applyStimulus(1'b0, 3'd4, 32'h1001, 32'h0);

        noStall = 1'b1;
        applyStimulus(1'b0, 3'd2, 32'h1008, 32'h0);
        noStall = 1'b0;
        applyStimulus(1'b0, 3'd2, 32'h1004, 32'h0);

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h1010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstMemread", 32'(memread), 32'd0);
        checkOutput("midRstAddr", addr, 32'h0);
        checkOutput("midRstMask", 32'(sign_mask), 32'd0);
        checkOutput("midRstRespValid", 32'(resp_valid), 32'd0);
        checkOutput("midRstReadyLow", 32'(req_ready), 32'd0);
        @(negedge clk);
        checkOutput("midRstReadyHigh", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midRstNoResp", 32'(resp_valid), 32'd0);
        end
        applyStimulus(1'b0, 3'd2, 32'h1004, 32'h0);

        for (int n = 0; n < 40; n++) begin
            rWe = 1'($urandom_range(0, 1));
            rF3 = 3'($urandom_range(0, 7));
            rA  = 32'h1000 + 32'($urandom_range(0, 252));
            if ($urandom_range(0, 1) == 1) rA[1:0] = 2'b00;
            applyStimulus(rWe, rF3, rA, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
